// File: rtl/nor_share_arbiter.sv
// Round-robin sequencer that time-shares one NOR gate among NUM_REQ requesters.
// Defining NOR_SHARE_STATS_EN adds the saturating op_count output.

module nor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a | b);
endmodule

module nor_share_chk #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               rsp_valid,
  input logic               rsp_ready,
  input logic               rsp_out,
  input logic [ID_W-1:0]    rsp_id
);
  // At most one requester is accepted per cycle
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  // No new grant while a response is outstanding
  a_no_grant_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !((|req_ready) && rsp_valid));

  // A stalled response holds its payload
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_out) && $stable(rsp_id)));
endmodule

module nor_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_in0,
  input  logic [NUM_REQ-1:0] req_in1,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_out,
  output logic [ID_W-1:0]    rsp_id
`ifdef NOR_SHARE_STATS_EN
  ,
  output logic [15:0]        op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic            op_a_r;
  logic            op_b_r;
  logic            res_r;
  logic            rsp_valid_r;
  logic [ID_W-1:0] gnt_id_r;
  logic [ID_W-1:0] rsp_id_r;
  logic [ID_W-1:0] last_r;
  logic [ID_W:0]   pick_s;
  logic            gate_y_s;

  // Returns {found, index}: first valid requester after 'last', wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] pick;
    int            idx;
    pick = {(ID_W+1){1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[idx]) begin
        pick = {1'b1, idx[ID_W-1:0]};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Round-robin winner selection
  always_comb begin
    pick_s = rr_pick(req_valid, last_r);
  end

  // Grant is combinational and only offered while idle
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (state_r == IDLE && pick_s[ID_W]) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s[ID_W-1:0];
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  nor_gate u_nor (
    .a (op_a_r),
    .b (op_b_r),
    .y (gate_y_s)
  );

  // Sequencer: accept, evaluate, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_a_r      <= 1'b0;
      op_b_r      <= 1'b0;
      res_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      gnt_id_r    <= {ID_W{1'b0}};
      rsp_id_r    <= {ID_W{1'b0}};
      last_r      <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_s[ID_W]) begin
            op_a_r   <= req_in0[pick_s[ID_W-1:0]];
            op_b_r   <= req_in1[pick_s[ID_W-1:0]];
            gnt_id_r <= pick_s[ID_W-1:0];
            last_r   <= pick_s[ID_W-1:0];
            state_r  <= EVAL;
          end else begin
            state_r  <= IDLE;
          end
        end
        EVAL: begin
          res_r       <= gate_y_s;
          rsp_id_r    <= gnt_id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_out   = res_r;
  assign rsp_id    = rsp_id_r;

`ifdef NOR_SHARE_STATS_EN
  logic [15:0] op_count_r;

  // Completed-handshake counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= 16'h0000;
    end else if (rsp_valid_r && rsp_ready && (op_count_r != 16'hFFFF)) begin
      op_count_r <= op_count_r + 16'h0001;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign op_count = op_count_r;
`endif

  nor_share_chk #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_id    (rsp_id)
  );

endmodule

// File: tb/tb_nor_share_arbiter.sv
// Self-checking bench for nor_share_arbiter: transaction-level model plus directed pins.
module tb_nor_share_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_valid = 4'b0000;
  logic [3:0] req_in0 = 4'b0000;
  logic [3:0] req_in1 = 4'b0000;
  logic [3:0] req_ready;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_out;
  logic [1:0] rsp_id;
`ifdef NOR_SHARE_STATS_EN
  logic [15:0] op_count;
`endif

  nor_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_id    (rsp_id)
`ifdef NOR_SHARE_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: a transaction is in flight from its grant cycle until its handshake;
  // its response is due two cycles after the grant.
  bit   inflight = 1'b0;
  int   t_grant = 0;
  int   cyc = 0;
  int   m_last = 3;
  int   m_id = 0;
  bit   m_res = 1'b0;
  int   m_cnt = 0;
  int   grants[$];
  int   gcyc[$];
  logic [3:0] g_rdy;
  logic       g_val, g_out;
  logic [1:0] g_id;

  task automatic checkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx = (last + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    inflight = 1'b0;
    m_last = 3;
    m_cnt = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model
  task automatic step(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b, input logic rr);
    int w;
    logic [3:0] er;
    logic ev;
    @(negedge clk);
    req_valid = v; req_in0 = a; req_in1 = b; rsp_ready = rr;
    #1;
    w  = inflight ? -1 : rr_pick(v, m_last);
    er = (w >= 0) ? 4'(1 << w) : 4'b0000;
    ev = inflight && (cyc >= t_grant + 2);
    checkv("req_ready", 32'(req_ready), 32'(er));
    checkv("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      checkv("rsp_out", 32'(rsp_out), 32'(m_res));
      checkv("rsp_id", 32'(rsp_id), 32'(m_id));
    end
`ifdef NOR_SHARE_STATS_EN
    checkv("op_count", 32'(op_count), 32'(m_cnt));
`endif
    g_rdy = req_ready; g_val = rsp_valid; g_out = rsp_out; g_id = rsp_id;
    if (req_ready != 4'b0000) begin
      grants.push_back($clog2(req_ready));
      gcyc.push_back(cyc);
    end
    if (w >= 0) begin
      inflight = 1'b1; t_grant = cyc; m_id = w; m_last = w;
      m_res = !(a[w] || b[w]);
    end else if (ev && rr) begin
      inflight = 1'b0;
      if (m_cnt < 65535) m_cnt++;
    end
    cyc++;
  endtask

  // Directed single operation for requester r with hand-computed result
  task automatic op(input int r, input logic a, input logic b, input int stall, input logic exp);
    logic [3:0] v;
    v = 4'(1 << r);
    step(v, a ? v : 4'b0000, b ? v : 4'b0000, 1'b1);
    checkv("op_grant", 32'(g_rdy), 32'(v));
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkv("op_eval_novalid", 32'(g_val), 32'd0);
    for (int i = 0; i < stall; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkv("op_rsp_valid", 32'(g_val), 32'd1);
    checkv("op_rsp_out", 32'(g_out), 32'(exp));
    checkv("op_rsp_id", 32'(g_id), 32'(r));
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    #1;
    checkv("rst_req_ready", 32'(req_ready), 32'd0);
    checkv("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkv("rst_rsp_out", 32'(rsp_out), 32'd0);
    checkv("rst_rsp_id", 32'(rsp_id), 32'd0);
`ifdef NOR_SHARE_STATS_EN
    checkv("rst_op_count", 32'(op_count), 32'd0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_g[5] = '{0, 1, 2, 3, 0};
    hard_reset();

    // Truth table through requester 0
    op(0, 1'b0, 1'b0, 0, 1'b1);
    op(0, 1'b0, 1'b1, 0, 1'b0);
    op(0, 1'b1, 1'b0, 0, 1'b0);
    op(0, 1'b1, 1'b1, 0, 1'b0);

    // Reset during EVAL aborts the operation
    step(4'b0001, 4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    hard_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'b0000, 4'b0000, 1'b1);
      checkv("post_rst_novalid", 32'(g_val), 32'd0);
    end

    // Contention from reset: 0,1,2,3,0 every three cycles
    grants.delete(); gcyc.delete();
    for (int i = 0; i < 13; i++) step(4'hF, 4'($urandom), 4'($urandom), 1'b1);
    checkv("cont_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) begin
        checkv("cont_order", 32'(grants[i]), 32'(exp_g[i]));
        if (i > 0) checkv("cont_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
      end
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Round-robin skip with last = 1
    op(1, 1'b0, 1'b0, 0, 1'b1);
    grants.delete(); gcyc.delete();
    for (int i = 0; i < 6; i++) step(4'b1010, 4'b0000, 4'b1000, 1'b1);
    checkv("skip_count", 32'(grants.size()), 32'd2);
    if (grants.size() >= 2) begin
      checkv("skip_first", 32'(grants[0]), 32'd3);
      checkv("skip_second", 32'(grants[1]), 32'd1);
    end

    // Backpressure: 5 stalled cycles with every requester waiting
    step(4'b0100, 4'b0000, 4'b0000, 1'b0);
    checkv("bp_grant", 32'(g_rdy), 32'h4);
    step(4'hF, 4'($urandom), 4'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 4'($urandom), 4'($urandom), 1'b0);
      checkv("bp_ready", 32'(g_rdy), 32'd0);
      checkv("bp_valid", 32'(g_val), 32'd1);
      checkv("bp_out", 32'(g_out), 32'd1);
      checkv("bp_id", 32'(g_id), 32'd2);
    end
    step(4'hF, 4'($urandom), 4'($urandom), 1'b1);
    step(4'hF, 4'($urandom), 4'($urandom), 1'b1);
    checkv("bp_next_grant", 32'(g_rdy), 32'h8);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 10; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b1);

`ifdef NOR_SHARE_STATS_EN
    hard_reset();
    op(0, 1'b0, 1'b0, 0, 1'b1);
    op(1, 1'b1, 1'b0, 4, 1'b0);
    op(2, 1'b0, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkv("stats_three", 32'(op_count), 32'd3);
    #2 force dut.op_count_r = 16'hFFFD;
    #1 release dut.op_count_r;
    m_cnt = 65533;
    for (int i = 0; i < 4; i++) op(i, 1'b1, 1'b1, 0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkv("stats_saturate", 32'(op_count), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
